// File: rtl/app_ini_loader_pkg.sv
// Shared definitions for the initial-APP loader: mode codes, block lengths,
// segment boundaries and FSM states.
package app_ini_loader_pkg;

  localparam logic [2:0] MODE_R23 = 3'd1;
  localparam logic [2:0] MODE_R78 = 3'd2;

  localparam int EXP_R23 = 176;
  localparam int EXP_R78 = 48;

  localparam int SEG_B0 = 16;
  localparam int SEG_B1 = 32;
  localparam int SEG_B2 = 48;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_DEC = 2'd2
  } state_t;

  function automatic logic [1:0] seg_of(input logic [7:0] beat);
    if (int'(beat) < SEG_B0)      return 2'd0;
    else if (int'(beat) < SEG_B1) return 2'd1;
    else if (int'(beat) < SEG_B2) return 2'd2;
    else                          return 2'd3;
  endfunction

  function automatic logic mode_ok(input logic [2:0] m);
    return (m == MODE_R23) || (m == MODE_R78);
  endfunction

endpackage

// File: rtl/app_ini_loader_beat_counter.sv
// Beat counter for one block: holds the next write address, flags the final
// and overrun positions for the latched mode, and decodes the beat segment.
module app_beat_counter
  import app_ini_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              set1,
  input  logic              inc,
  input  logic [2:0]        mode,
  output logic [ADDR_W-1:0] cnt,
  output logic              at_final,
  output logic              at_exp,
  output logic [1:0]        seg
);

  logic [ADDR_W-1:0] exp_len;

  assign exp_len  = (mode == MODE_R23) ? ADDR_W'(EXP_R23) : ADDR_W'(EXP_R78);
  assign at_final = (cnt == exp_len - 1'b1);
  assign at_exp   = (cnt >= exp_len);
  assign seg      = seg_of(8'(cnt));

  // A restart beat takes priority over the clear that leaving LOAD would imply.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (set1) cnt <= ADDR_W'(1);
    else if (clr)  cnt <= '0;
    else if (inc)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/app_ini_loader.sv
// Initial-APP buffer stream loader: frames beats against the code-rate mode and
// writes them to APP memory. Define APP_SUBX_CHECK_EN to verify segment indices.
module app_ini_loader
  import app_ini_loader_pkg::*;
#(
  parameter int LANES   = 8,
  parameter int LANE_W  = 384*6,
  parameter int ADDR_W  = 8,
  parameter int BLK_NUM = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*LANE_W-1:0] APPmsg_ini_subx,
  input  logic [1:0]              APPmsg_ini_sub_x,
  input  logic                    buffer_valid,
  input  logic                    buffer_start,
  input  logic                    buffer_last,
  input  logic [2:0]              iLs,
  input  logic                    dec_done,
  output logic                    buffer_ready,
  output logic                    app_we,
  output logic [ADDR_W-1:0]       app_waddr,
  output logic [LANES*LANE_W-1:0] app_wdata,
  output logic                    load_done,
  output logic [2:0]              load_mode,
  output logic [2:0]              blk_cnt,
  output logic                    all_loaded,
  output logic                    err
);

`ifdef APP_SUBX_CHECK_EN
  localparam bit SUBX_CHECK = 1'b1;
`else
  localparam bit SUBX_CHECK = 1'b0;
`endif

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt;
  logic              at_final, at_exp;
  logic [1:0]        seg;
  logic              start_ok, beat_sub_ok, start_sub_ok;
  logic              wr, addr0, done_c, err_c, set1, inc;

  app_beat_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_n != LOAD),
    .set1     (set1),
    .inc      (inc),
    .mode     (load_mode),
    .cnt      (cnt),
    .at_final (at_final),
    .at_exp   (at_exp),
    .seg      (seg)
  );

  assign start_sub_ok = !SUBX_CHECK || (APPmsg_ini_sub_x == 2'd0);
  assign beat_sub_ok  = !SUBX_CHECK || (APPmsg_ini_sub_x == seg);
  assign start_ok     = mode_ok(iLs) && start_sub_ok;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:
        if (buffer_valid && buffer_start && start_ok) state_n = LOAD;
      LOAD:
        if (buffer_valid) begin
          if (buffer_start)     state_n = start_ok ? LOAD : IDLE;
          else if (!beat_sub_ok) state_n = IDLE;
          else if (buffer_last) state_n = at_final ? WAIT_DEC : IDLE;
          else if (at_exp)      state_n = IDLE;
        end
      WAIT_DEC:
        if (dec_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    wr     = 1'b0;
    addr0  = 1'b0;
    done_c = 1'b0;
    err_c  = 1'b0;
    set1   = 1'b0;
    inc    = 1'b0;
    case (state)
      IDLE:
        if (buffer_valid && buffer_start) begin
          if (start_ok) begin wr = 1'b1; addr0 = 1'b1; set1 = 1'b1; end
          else          err_c = 1'b1;
        end
      LOAD:
        if (buffer_valid) begin
          if (buffer_start) begin
            // Restart: flag the aborted block, then take this beat as beat 0.
            err_c = 1'b1;
            if (start_ok) begin wr = 1'b1; addr0 = 1'b1; set1 = 1'b1; end
          end else if (!beat_sub_ok) begin
            err_c = 1'b1;
          end else if (buffer_last) begin
            if (at_final) begin wr = 1'b1; done_c = 1'b1; end
            else          err_c = 1'b1;
          end else if (at_exp) begin
            err_c = 1'b1;
          end else begin
            wr  = 1'b1;
            inc = 1'b1;
          end
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      app_we       <= 1'b0;
      app_waddr    <= '0;
      app_wdata    <= '0;
      load_done    <= 1'b0;
      err          <= 1'b0;
      buffer_ready <= 1'b0;
      load_mode    <= '0;
      blk_cnt      <= '0;
      all_loaded   <= 1'b0;
    end else begin
      app_we       <= wr;
      load_done    <= done_c;
      err          <= err_c;
      buffer_ready <= (state_n == IDLE);
      if (wr) begin
        app_waddr <= addr0 ? '0 : cnt;
        app_wdata <= APPmsg_ini_subx;
      end
      if (set1) load_mode <= iLs;
      if (done_c) begin
        if (blk_cnt == 3'(BLK_NUM-1)) begin
          blk_cnt    <= '0;
          all_loaded <= 1'b1;
        end else begin
          blk_cnt <= blk_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/app_ini_loader.md
Name: app_ini_loader

Overview:
- Receiving end of the decoder's initial-APP buffer stream.
- Accepts beats qualified by buffer_valid/buffer_start/buffer_last with segment index APPmsg_ini_sub_x, checks framing against the code-rate mode iLs, and writes each beat into the APP message memory.
- Drives buffer_ready back to the stream source and hands completed blocks to the decoder core.
- Sits between the external buffer sequencer and the layered decoder core.

Parameters:
- LANES, 8, number of parallel sub-lanes per beat
- LANE_W, 384*6, bits per lane (Zc*VWidth)
- ADDR_W, 8, APP write address width (beat index 0..175)
- BLK_NUM, 8, blocks per decoder batch (BlkNumperDecoder)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- APPmsg_ini_subx  in  LANES*LANE_W  packed lane data; lane k at bits [k*LANE_W +: LANE_W]
- APPmsg_ini_sub_x  in  2  segment index of current beat
- buffer_valid  in  1  beat valid
- buffer_start  in  1  first beat of block; coincides with buffer_valid
- buffer_last  in  1  final beat of block; coincides with buffer_valid
- iLs  in  3  mode: 1 = rate 2/3 (176 beats), 2 = rate 7/8 (48 beats)
- dec_done  in  1  one-cycle pulse from core: block consumed
- buffer_ready  out  1  loader can accept a new block
- app_we  out  1  APP memory write enable
- app_waddr  out  ADDR_W  beat index
- app_wdata  out  LANES*LANE_W  registered copy of lane data
- load_done  out  1  pulse: block fully and correctly loaded
- load_mode  out  3  iLs latched at block start
- blk_cnt  out  3  blocks loaded in current batch
- all_loaded  out  1  sticky: BLK_NUM blocks loaded
- err  out  1  pulse: framing error, block dropped

Behaviour:
- Reset: all outputs 0; state IDLE; beat counter 0. buffer_ready is registered, so it reads 1 only from the cycle after reset deasserts.
- States: IDLE, LOAD, WAIT_DEC.
- Expected length EXP = 176 for mode 1, 48 for mode 2.
- Segment of beat b:
  - b < 16 → 0; b < 32 → 1; b < 48 → 2; otherwise 3.
  - Segment 3 exists in mode 1 only.
- IDLE:
  - buffer_ready = 1.
  - On buffer_valid & buffer_start with iLs ∈ {1,2}: latch load_mode, write beat 0, counter := 1, go to LOAD.
  - If iLs is any other value: err pulse, stay in IDLE.
  - buffer_valid without buffer_start: ignored, no write.
- LOAD:
  - buffer_ready = 0.
  - Each valid beat writes at address = counter, then counter increments. Valid gaps hold all state.
  - buffer_valid & buffer_last with counter == EXP-1: write the beat, load_done pulse, blk_cnt += 1, go to WAIT_DEC.
  - buffer_last with counter ≠ EXP-1: err pulse, no write, go to IDLE.
  - Counter reaches EXP without buffer_last: err pulse, go to IDLE. The excess beat is not written.
  - buffer_start in LOAD: err pulse, then restart as a new block. That beat is written at address 0 and the counter becomes 1.
- WAIT_DEC:
  - buffer_ready = 0; incoming beats are ignored.
  - dec_done → IDLE.
  - dec_done arriving in any other state is ignored.
- Write timing:
  - app_we, app_waddr and app_wdata are registered, 1 cycle after the accepted beat.
  - load_done and err are registered together with the final write.
  - load_done also lags 1 cycle.
- blk_cnt and all_loaded:
  - blk_cnt wraps from BLK_NUM-1 to 0.
  - all_loaded goes high on the increment from BLK_NUM-1 and stays high until rst.
- Reset mid-LOAD:
  - Any pending write is cancelled; app_we = 0 on the next cycle.
  - Partial block is discarded.

Optional Feature:
- Macro: APP_SUBX_CHECK_EN.
- Defined: every accepted beat in LOAD, and the start beat, compares APPmsg_ini_sub_x with the segment of its beat index. On mismatch: err pulse, beat not written, return to IDLE.
- Not defined: APPmsg_ini_sub_x is ignored and the address derives only from the counter.

Decomposition:
- Shared package holds:
  - mode encodings MODE_R23 = 1, MODE_R78 = 2
  - EXP lengths 176 and 48
  - segment boundaries 16/32/48
  - state enum
- One natural sub-module: app_beat_counter (counter, EXP compare, segment decode). The FSM and write register stay at top level.

Test Plan:
- Mode 2, 48 contiguous beats, start on beat 0, last on beat 47 → app_we for 48 cycles at addresses 0..47; load_done 1 cycle after beat 47; buffer_ready 0 until dec_done.
- Mode 1, 176 beats with valid dropped for 3 cycles at beat 100 → addresses 0..175 with no gap corruption; load_done once; blk_cnt = 1.
- Mode 2, buffer_last on beat 30 → err pulse, no write for beat 30, state IDLE, buffer_ready = 1 next cycle.
- Eight consecutive good mode-2 blocks, each followed by dec_done → blk_cnt 1..7 then 0; all_loaded = 1 after the 8th block.
- rst asserted at beat 20 of a mode-1 block → all outputs 0 next cycle; a new block then loads from address 0.
- With APP_SUBX_CHECK_EN defined, sub_x = 1 on beat 10 → err; without the macro, same stimulus → normal load_done.
